// File: rtl/mmio_tx_queue_pkg.sv
// mmio_tx_queue_pkg: shared constants for the MMIO transmit queue.
//   - Register window word addresses (address[1:0] once address[13:2]==0)
//   - STATUS bit positions and CTRL bit positions
//   - pack_status(): assembles the STATUS read word
package mmio_tx_queue_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LEVEL  = 2'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;

    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLRFLAGS = 1;
    localparam int CTRL_PROBE    = 2;

    // bits[15:8] count, bits[7:4] zero, bits[3:0] udf/ovf/full/empty
    function automatic logic [15:0] pack_status(input logic [7:0] cnt,
                                                input logic empty,
                                                input logic full,
                                                input logic ovf,
                                                input logic udf);
        logic [15:0] s;
        s           = '0;
        s[15:8]     = cnt;
        s[ST_EMPTY] = empty;
        s[ST_FULL]  = full;
        s[ST_OVF]   = ovf;
        s[ST_UDF]   = udf;
        return s;
    endfunction

endpackage

// File: rtl/mmio_tx_queue_fifo.sv
// sync_fifo_core: single-clock FIFO of 16-bit words.
//   clk, reset    : clock, synchronous active-high reset (clears pointers/count)
//   push, wdata   : enqueue request; ignored when full (pre-edge count)
//   pop           : dequeue request; ignored when empty
//   flush         : empties the queue; wins over a same-edge push/pop
//   rdata         : word at the head (mem[rd_ptr])
//   count, empty, full : occupancy; empty/full come from count only
module sync_fifo_core #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [15:0]              wdata,
    output logic [15:0]              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop on the same edge never makes room for a push into a full queue.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)      count <= count + (PTR_W+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (PTR_W+1)'(1);
        end
    end

    // Storage has no reset; a write landing on a flush/reset edge is never
    // visible because the pointers restart at 0 with count 0.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_tx_queue.sv
// mmio_tx_queue: 4-word MMIO register window feeding a valid/ready stream.
//   clk, reset   : clock, synchronous active-high reset
//   in, address, load : word-RAM style bus write data, word address, write strobe
//   out          : combinational read data for address
//   tx_data, tx_valid, tx_ready : head-of-queue stream to the sink
// Registers: 0 DATA (push / peek), 1 STATUS, 2 CTRL (flush, clear, probe),
// 3 LEVEL (free slots). Anything with address[13:2]!=0 is unmapped.
module mmio_tx_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic [13:0] address,
    input  logic        load,
    output logic [15:0] out,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    import mmio_tx_queue_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic             mapped;
    logic [1:0]       sel;
    logic             wr_data;
    logic             wr_ctrl;
    logic             flush;
    logic             clr_flags;
    logic             set_ovf;
    logic             set_udf;
    logic             ovf;
    logic             udf;
    logic [15:0]      head;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    assign mapped    = (address[13:2] == '0);
    assign sel       = address[1:0];
    assign wr_data   = load && mapped && (sel == ADDR_DATA);
    assign wr_ctrl   = load && mapped && (sel == ADDR_CTRL);
    assign flush     = wr_ctrl && in[CTRL_FLUSH];
    assign clr_flags = wr_ctrl && in[CTRL_CLRFLAGS];
    assign set_ovf   = wr_data && full;
    // Probe: software expected data but the queue was empty.
    assign set_udf   = wr_ctrl && in[CTRL_PROBE] && empty;

    sync_fifo_core #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (tx_valid && tx_ready),
        .flush (flush),
        .wdata (in),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign tx_valid = !empty;
    assign tx_data  = head;

    // Sticky flags; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= set_ovf || (ovf && !clr_flags);
            udf <= set_udf || (udf && !clr_flags);
        end
    end

    // STATUS carries count in 8 bits; at DEPTH=256 a full queue reads 0 there
    // and the full bit disambiguates.
    always_comb begin
        out = '0;
        if (mapped) begin
            case (sel)
                ADDR_DATA:   if (!empty) out = head;
                ADDR_STATUS: out = pack_status(8'(count), empty, full, ovf, udf);
                ADDR_LEVEL:  out = 16'(DEPTH) - 16'(count);
                default:     out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_tx_queue.sv
// Scoreboard bench for mmio_tx_queue: the driver keeps a queue-based model of
// the FIFO and flags, pushes every accepted word to a scoreboard, and a
// separate monitor pops the scoreboard whenever the sink takes a word.
module tb_mmio_tx_queue;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] in = '0;
    logic [13:0] address = '0;
    logic [15:0] out;
    logic [15:0] tx_data;
    logic        tx_valid;

    mmio_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .address  (address),
        .load     (load),
        .out      (out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_q[$];
    logic [15:0] sb[$];
    bit          m_ovf = 0;
    bit          m_udf = 0;
    int          exp_xfers = 0;
    int          got_xfers = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [13:0] a);
        logic [15:0] r;
        int n;
        r = '0;
        n = m_q.size();
        if (a[13:2] == 12'd0) begin
            case (a[1:0])
                2'd0: if (n != 0) r = m_q[0];
                2'd1: r = {8'(n), 4'b0000, m_udf, m_ovf, n == DEPTH, n == 0};
                2'd3: r = 16'(DEPTH - n);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Effect of one posedge on the model, from the pre-edge state.
    task automatic model_edge(input logic ld, input logic [13:0] a,
                              input logic [15:0] d, input logic rdy);
        int n;
        bit full, empty, wd, wc, do_pop;
        n     = m_q.size();
        full  = (n == DEPTH);
        empty = (n == 0);
        wd    = ld && (a[13:2] == 12'd0) && (a[1:0] == 2'd0);
        wc    = ld && (a[13:2] == 12'd0) && (a[1:0] == 2'd2);
        if (reset) begin
            m_q.delete();
            sb.delete();
            m_ovf = 0;
            m_udf = 0;
            return;
        end
        do_pop = !empty && rdy;
        if (do_pop) exp_xfers++;
        m_ovf = (wd && full) || (m_ovf && !(wc && d[1]));
        m_udf = (wc && d[2] && empty) || (m_udf && !(wc && d[1]));
        if (wc && d[0]) begin
            m_q.delete();
            sb.delete();
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (wd && !full) begin
                m_q.push_back(d);
                sb.push_back(d);
            end
        end
    endtask

    // One bus cycle: drive, check outputs at negedge, advance model, clock.
    task automatic step(input logic ld, input logic [13:0] a, input logic [15:0] d,
                        input logic rdy, input string tag,
                        input bit use_c = 0, input logic [15:0] c = '0);
        load = ld; address = a; in = d; tx_ready = rdy;
        @(negedge clk);
        chk({tag, "_out"}, out, model_read(a));
        chk({tag, "_valid"}, 16'(tx_valid), 16'(m_q.size() != 0));
        if (m_q.size() != 0) chk({tag, "_txdata"}, tx_data, m_q[0]);
        if (use_c) chk({tag, "_const"}, out, c);
        #1;
        model_edge(ld, a, d, rdy);
        @(posedge clk);
        #1;
    endtask

    // Sink monitor: every accepted word must be the scoreboard head.
    always @(negedge clk) begin
        if (!reset && tx_valid === 1'b1 && tx_ready) begin
            got_xfers++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sink_unexpected: got %h expected none", tx_data);
            end else begin
                chk("sink_order", tx_data, sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: reset state
        step(0, 14'd1, 16'd0, 0, "t1_status", 1, 16'h0001);
        chk("t1_txvalid", 16'(tx_valid), 16'd0);
        step(0, 14'd0, 16'd0, 0, "t1_data", 1, 16'h0000);
        step(0, 14'h0100, 16'd0, 0, "t1_unmapped", 1, 16'h0000);

        // 2: three pushes, sink stalled
        step(1, 14'd0, 16'hAAAA, 0, "t2_push");
        step(1, 14'd0, 16'h5555, 0, "t2_push");
        step(1, 14'd0, 16'h1234, 0, "t2_push");
        step(0, 14'd1, 16'd0, 0, "t2_status", 1, 16'h0300);
        step(0, 14'd0, 16'd0, 0, "t2_peek", 1, 16'hAAAA);
        step(0, 14'd3, 16'd0, 0, "t2_level", 1, 16'h000D);
        chk("t2_txdata", tx_data, 16'hAAAA);

        // 3: drain
        repeat (3) step(0, 14'd1, 16'd0, 1, "t3_drain");
        step(0, 14'd1, 16'd0, 0, "t3_status", 1, 16'h0001);
        chk("t3_txvalid", 16'(tx_valid), 16'd0);

        // 4: overflow
        for (int i = 0; i <= 16; i++) step(1, 14'd0, 16'(i), 0, "t4_push");
        step(0, 14'd1, 16'd0, 0, "t4_status", 1, 16'h1006);
        repeat (16) step(0, 14'd0, 16'd0, 1, "t4_drain");
        step(0, 14'd1, 16'd0, 0, "t4_empty", 1, 16'h0005);
        step(1, 14'd2, 16'h0002, 0, "t4_clr");
        step(0, 14'd1, 16'd0, 0, "t4_status2", 1, 16'h0001);

        // 5: push on full with same-edge pop is dropped; push+pop at 5 holds
        for (int i = 0; i < 16; i++) step(1, 14'd0, 16'h0100 + 16'(i), 0, "t5_fill");
        step(1, 14'd0, 16'hBEEF, 1, "t5_full_pp");
        step(0, 14'd1, 16'd0, 0, "t5_status15", 1, 16'h0F04);
        repeat (10) step(0, 14'd1, 16'd0, 1, "t5_drain");
        step(1, 14'd0, 16'hBEEF, 1, "t5_pp5");
        step(0, 14'd1, 16'd0, 0, "t5_status5", 1, 16'h0504);
        step(1, 14'd2, 16'h0003, 0, "t5_flushclr");
        step(0, 14'd1, 16'd0, 0, "t5_status0", 1, 16'h0001);

        // probe / set-wins / ignored writes
        step(1, 14'd2, 16'h0004, 0, "pr_probe");
        step(0, 14'd1, 16'd0, 0, "pr_status", 1, 16'h0009);
        step(1, 14'd2, 16'h0006, 0, "pr_setwins");
        step(0, 14'd1, 16'd0, 0, "pr_status2", 1, 16'h0009);
        step(1, 14'd2, 16'h0002, 0, "pr_clr");
        step(1, 14'h0104, 16'h7777, 0, "pr_unmapped_wr");
        step(1, 14'd1, 16'hFFFF, 0, "pr_status_wr");
        step(1, 14'd3, 16'hFFFF, 0, "pr_level_wr");
        step(0, 14'd1, 16'd0, 0, "pr_status3", 1, 16'h0001);

        // 6: random interleaving across the pointer wrap
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [13:0] a;
            r = $urandom_range(0, 9);
            a = (r < 6) ? 14'd0 : (r == 6) ? 14'd1 : (r == 7) ? 14'd3 : 14'h0100;
            step($urandom_range(0, 3) != 0, a, 16'($urandom), $urandom_range(0, 2) == 0, "t6_rand");
        end
        repeat (3) step(1, 14'd0, 16'($urandom), 0, "t6_prefill");
        step(1, 14'd2, 16'h0003, 1, "t6_flush");
        step(0, 14'd1, 16'd0, 0, "t6_flush_st", 1, 16'h0001);
        for (int i = 0; i < 4; i++) step(1, 14'd0, 16'hC000 + 16'(i), 0, "t6_push4");
        reset = 1'b1;
        step(0, 14'd1, 16'd0, 0, "t6_rst");
        reset = 1'b0;
        chk("t6_rst_txvalid", 16'(tx_valid), 16'd0);
        step(0, 14'd1, 16'd0, 0, "t6_rst_status", 1, 16'h0001);

        chk("xfer_count", 16'(got_xfers), 16'(exp_xfers));
        chk("sb_leftover", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_tx_queue.md
Name: mmio_tx_queue

Overview:
- Memory-mapped responder on the team's word-RAM bus: in[15:0], address[13:0], load, out[15:0]. From the CPU it looks like a 4-word register window.
- The CPU pushes 16-bit words into an internal FIFO through a DATA register.
- An external sink drains the FIFO over a valid/ready stream.
- It sits beside the RAM/screen blocks in the data-memory map and is the responder for the same bus the CPU-side drivers initiate on.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, 2..256.
- PTR_W, 4, log2(DEPTH); derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in  in  16  bus write data.
- address  in  14  bus word address; only 0..3 decode.
- load  in  1  bus write strobe, sampled at posedge.
- out  out  16  bus read data; combinational from address and current state.
- tx_data  out  16  head-of-queue word.
- tx_valid  out  1  high when queue not empty.
- tx_ready  in  1  sink accepts tx_data when tx_valid && tx_ready at posedge.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). While reset is high at a posedge:
  - count, rd_ptr, wr_ptr, ovf and udf clear to 0.
  - Storage contents are don't-care.
  - After reset: tx_valid=0; out=0x0000 at addr 0 and 0x0001 at addr 1.
- Register map (address[13:2] must be 0, otherwise the access is unmapped):
  - 0 DATA
    - Read: returns the head word, or 0 if empty. Peek only, no pop.
    - Write: push in.
  - 1 STATUS (read-only; writes ignored)
    - bit0 empty, bit1 full, bit2 ovf (sticky), bit3 udf (sticky).
    - bits[15:8] count; bits[7:4]=0.
    - count needs PTR_W+1 bits, zero-extended.
  - 2 CTRL (write-only; reads 0)
    - in[0]=1: flush.
    - in[1]=1: clear ovf and udf.
    - Both bits may be set together.
  - 3 LEVEL: reads DEPTH-count (free slots); writes ignored.
  - Unmapped: reads 0x0000, writes ignored.
- Read latency: out is 0 cycles (combinational, like RAM out). A push is visible on STATUS/DATA the cycle after the posedge.
- Push (load && DATA selected):
  - Accepted iff count<DEPTH, using the pre-edge count.
  - When accepted: mem[wr_ptr]<=in, wr_ptr+1 mod DEPTH.
  - When full: word dropped, ovf<=1. A same-cycle pop does not make room.
- Pop (tx_valid && tx_ready): rd_ptr+1 mod DEPTH. tx_data is mem[rd_ptr].
- Underflow: a DATA read while empty is not an error. udf is set only by a CTRL write with in[2]=1 while empty (software "expect-data" probe); otherwise udf holds.
- count update:
  - push&&pop: unchanged.
  - push only: +1.
  - pop only: -1.
- Pointer wrap at DEPTH is silent; empty/full come from count, never from pointer equality.
- Flush:
  - Next cycle: count=0 and rd_ptr=wr_ptr=0.
  - Priority over a same-edge push/pop. The sink still considers a word accepted on that edge transferred.
  - ovf/udf are unaffected unless in[1].
- Flag set and clear on the same edge: set wins.
- Reset mid-stream: queued words are lost, and tx_valid drops the cycle after reset is sampled.
- tx_data is stable while tx_valid && !tx_ready. A push into a non-empty queue never changes tx_data.

Decomposition:
- Package mmio_tx_queue_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_LEVEL=3.
  - STATUS bit indices.
  - CTRL bit indices FLUSH=0, CLRFLAGS=1, PROBE=2.
- One natural sub-module, sync_fifo_core:
  - Storage, pointers, count, push/pop/flush, empty/full.
  - The top keeps address decode, flags, out mux and stream outputs.

Test Plan:
1. Reset, then read addr 1 → out=0x0001, tx_valid=0. Read addr 0 → 0x0000. Read addr 0x0100 → 0x0000.
2. tx_ready=0; write 0xAAAA, 0x5555, 0x1234 to addr 0.
   - Read addr 1 → 0x0300.
   - Read addr 0 → 0xAAAA.
   - Read addr 3 → 0x000D.
   - tx_data=0xAAAA.
3. Raise tx_ready for 3 cycles → sink sees 0xAAAA, 0x5555, 0x1234 in order. tx_valid then drops; STATUS=0x0001.
4. tx_ready=0; write 0x0000..0x0010 (17 words).
   - STATUS=0x1006 (count 16, full, ovf).
   - Drain all 16 → sink sees 0x0000..0x000F; 0x0010 is absent.
   - Write CTRL=0x0002 → STATUS=0x0001.
5. Fill 16, set tx_ready=1, push 0xBEEF on the same edge as a pop → push dropped, ovf=1, count=15. Repeat at count=5 → count stays 5.
6. Wrap test: 40 push/pop interleavings crossing the pointer wrap; the sink order matches the scoreboard.
   - Write CTRL=0x0001 mid-stream with push on the same edge → STATUS empty next cycle.
   - Assert reset with 4 queued → tx_valid=0 the next cycle.
